lms_sample_sequencer: RTL and testbench
=======================================

Name: lms_sample_sequencer

Overview:
- Schedules the LMS noise-cancellation engine against the codec sample stream.
- Collects one primary sample (d, left) and one reference sample (x, right) per frame from the codec receive bus.
- Launches one filter/adapt pass on the engine, then commits the error sample to the codec transmit bus.
- Sits between audio_codec and the LMS engine. Also handles bypass, overrun detection and an engine-hang watchdog.

Parameters:
- TIMEOUT, 1024: max clk cycles to wait for filt_done after filt_start.
- CNT_W, 8: width of the overrun counter.

Ports:
- clk  in  1  main clock; all inputs are synchronous to it (CDC lives outside this block).
- reset_n  in  1  asynchronous, active-low reset.
- sample_end  in  2  one-cycle capture strobes from codec; [1]=left/d, [0]=right/x.
- sample_req  in  2  codec transmit requests; informational, no effect on state.
- audio_input  in  16  signed codec receive sample, valid while a sample_end bit is high.
- audio_output  out  16  signed committed output sample, held between commits.
- bypass  in  1  1 = pass d straight to output with no engine pass.
- adapt_en  in  1  sampled at launch and forwarded as filt_adapt.
- filt_start  out  1  one-cycle launch pulse to engine.
- filt_d  out  16  latched primary sample, stable from launch until commit.
- filt_x  out  16  latched reference sample, stable from launch until commit.
- filt_adapt  out  1  weight-update enable for this pass.
- filt_done  in  1  engine completion pulse.
- filt_err  in  16  signed engine error output, valid with filt_done.
- busy  out  1  high in START and BUSY states.
- overrun_cnt  out  CNT_W  count of dropped captures; saturates at all-ones.
- timeout_flag  out  1  sticky; set on watchdog expiry.

Behaviour:
- Reset (async assert, sync release): state=COLLECT; d_ok=x_ok=0; audio_output=0; filt_d=filt_x=0; filt_start=0; filt_adapt=0; overrun_cnt=0; timeout_flag=0; watchdog=0.

COLLECT:
- sample_end[1] → latch audio_input into filt_d, set d_ok.
- sample_end[0] → latch audio_input into filt_x, set x_ok.
- Both bits in the same cycle → latch the same word into both, set both flags.
- A repeat capture of the same channel before the pair completes overwrites the register; it is not an overrun.
- When d_ok and x_ok are both set (including the same cycle the second capture lands), next state:
  - BYPASS if bypass=1;
  - otherwise START.

START:
- filt_start=1 for exactly one cycle.
- filt_adapt<=adapt_en.
- Clear watchdog. Next state BUSY.

BUSY:
- Watchdog increments each cycle.
- filt_done=1 → audio_output<=filt_err, next COMMIT.
- Else if watchdog reaches TIMEOUT-1 → audio_output<=filt_d (pass-through), timeout_flag<=1, next COMMIT.
- filt_done and watchdog expiry in the same cycle → done wins; timeout_flag is not set.

BYPASS:
- audio_output<=filt_d. Next COMMIT.

COMMIT:
- Clear d_ok and x_ok. Next COLLECT.

Overrun and stray inputs:
- Any sample_end bit arriving in START, BUSY, BYPASS or COMMIT is dropped; filt_d/filt_x are not modified.
- overrun_cnt increments by 1 per cycle with any bit set, saturating.
- filt_done outside BUSY is ignored.
- bypass and adapt_en changes take effect only at the next pair completion.

Latency:
- Second capture at cycle N → filt_start at N+1.
- filt_done at cycle M → audio_output valid at M+1.
- Bypass: audio_output valid at N+2.

Arithmetic:
- No width change. filt_err is passed through unmodified (saturation is the engine's job).

Reset mid-operation:
- Abort immediately to reset values; a launched engine pass is abandoned.
- Its later filt_done is ignored, since the state is no longer BUSY.

Test Plan:
- Normal pass: end[1] with 0x1234, then end[0] with 0x0F00 at cycle N; adapt_en=1 → filt_start single pulse at N+1, filt_d=0x1234, filt_x=0x0F00, filt_adapt=1; filt_done with filt_err=0xFFF0 at M → audio_output=0xFFF0 at M+1, busy low one cycle later.
- Bypass: bypass=1; d=0x7FFF, x=0x0001 → no filt_start; audio_output=0x7FFF at N+2.
- Overrun: during BUSY pulse end[1] three times and end[0] once, separately → overrun_cnt=4; filt_d/filt_x unchanged. Force 300 drops with CNT_W=8 → saturates at 255.
- Watchdog: TIMEOUT=16, never assert filt_done → audio_output=filt_d at launch+17, timeout_flag=1 and stays 1 across later normal passes. Then assert done on the expiry cycle in a fresh pass → audio_output=filt_err, timeout_flag unchanged.
- Simultaneous/overwrite: end[1] twice (0x0100, then 0x0200) before end[0] → filt_d=0x0200, no overrun. Both bits together with 0x0055 → filt_d=filt_x=0x0055, launch next cycle.
- Reset mid-BUSY: drop reset_n during BUSY → all outputs zero immediately. After release, a stray filt_done produces no commit, and the next pair runs normally.

Source files
------------

// File: rtl/lms_sample_sequencer_if.sv
// lms_sample_sequencer_if: codec, engine and control signals of the LMS sample sequencer.
interface lms_sample_sequencer_if #(parameter int CNT_W = 8);
    logic [1:0]       sample_end;
    logic [1:0]       sample_req;
    logic [15:0]      audio_input;
    logic [15:0]      audio_output;
    logic             bypass;
    logic             adapt_en;
    logic             filt_start;
    logic [15:0]      filt_d;
    logic [15:0]      filt_x;
    logic             filt_adapt;
    logic             filt_done;
    logic [15:0]      filt_err;
    logic             busy;
    logic [CNT_W-1:0] overrun_cnt;
    logic             timeout_flag;

    modport master (
        output sample_end, sample_req, audio_input, bypass, adapt_en, filt_done, filt_err,
        input  audio_output, filt_start, filt_d, filt_x, filt_adapt, busy, overrun_cnt, timeout_flag
    );
    modport slave (
        input  sample_end, sample_req, audio_input, bypass, adapt_en, filt_done, filt_err,
        output audio_output, filt_start, filt_d, filt_x, filt_adapt, busy, overrun_cnt, timeout_flag
    );
endinterface

// File: rtl/lms_sample_sequencer.sv
// lms_sample_sequencer: pairs codec d/x samples, runs one LMS engine pass per frame and commits the error sample.
module lms_sample_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    lms_sample_sequencer_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT);
    typedef enum logic [2:0] {COLLECT, START, BUSY, BYPASS, COMMIT} state_t;
    state_t           state, state_n;
    logic             d_ok, x_ok, pair, wd_exp, timeout_flag, filt_adapt;
    logic [15:0]      filt_d, filt_x, audio_output;
    logic [CNT_W-1:0] overrun_cnt;
    logic [WD_W-1:0]  wd;
    logic             unused_req;
    assign unused_req = ^bus.sample_req;
    assign pair   = state == COLLECT && (d_ok || bus.sample_end[1]) && (x_ok || bus.sample_end[0]);
    assign wd_exp = wd == WD_W'(TIMEOUT - 1);
    always_comb begin
        state_n = state;
        case (state)
            COLLECT: state_n = pair ? (bus.bypass ? BYPASS : START) : COLLECT;
            START:   state_n = BUSY;
            BUSY:    state_n = (bus.filt_done || wd_exp) ? COMMIT : BUSY;
            BYPASS:  state_n = COMMIT;
            default: state_n = COLLECT;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= COLLECT;
            d_ok         <= 1'b0;
            x_ok         <= 1'b0;
            filt_d       <= '0;
            filt_x       <= '0;
            filt_adapt   <= 1'b0;
            audio_output <= '0;
            overrun_cnt  <= '0;
            timeout_flag <= 1'b0;
            wd           <= '0;
        end else begin
            state <= state_n;
            if (state == COLLECT) begin
                if (bus.sample_end[1]) begin
                    filt_d <= bus.audio_input;
                    d_ok   <= 1'b1;
                end
                if (bus.sample_end[0]) begin
                    filt_x <= bus.audio_input;
                    x_ok   <= 1'b1;
                end
            end else if (|bus.sample_end && overrun_cnt != '1) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
            // adapt_en is latched with the pair so filt_adapt is already valid alongside filt_start
            if (pair) filt_adapt <= bus.adapt_en;
            if (state == START) wd <= '0;
            if (state == BUSY) begin
                wd <= wd + 1'b1;
                if (bus.filt_done) audio_output <= bus.filt_err;
                else if (wd_exp) begin
                    audio_output <= filt_d;
                    timeout_flag <= 1'b1;
                end
            end
            if (state == BYPASS) audio_output <= filt_d;
            if (state == COMMIT) begin
                d_ok <= 1'b0;
                x_ok <= 1'b0;
            end
        end
    end
    assign bus.filt_start   = state == START;
    assign bus.busy         = state == START || state == BUSY;
    assign bus.filt_d       = filt_d;
    assign bus.filt_x       = filt_x;
    assign bus.filt_adapt   = filt_adapt;
    assign bus.audio_output = audio_output;
    assign bus.overrun_cnt  = overrun_cnt;
    assign bus.timeout_flag = timeout_flag;
endmodule

// File: tb/tb_lms_sample_sequencer.sv
// tb_lms_sample_sequencer: directed and randomized frames checked against a transaction-level model of the sequencer.
module tb_lms_sample_sequencer;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int SAT     = 2**CNT_W - 1;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_out = '0;
    logic        exp_to  = 1'b0;
    int          exp_ovr = 0;

    lms_sample_sequencer_if #(.CNT_W(CNT_W)) bus ();
    lms_sample_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop();
        exp_ovr = exp_ovr < SAT ? exp_ovr + 1 : SAT;
    endtask

    task automatic capture(input logic [1:0] bits, input logic [15:0] val);
        bus.sample_end  = bits;
        bus.audio_input = val;
        tick();
        bus.sample_end  = 2'b00;
        bus.audio_input = 16'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"}, bus.audio_output, 16'h0);
        chk({tag, "_fd"}, bus.filt_d, 16'h0);
        chk({tag, "_fx"}, bus.filt_x, 16'h0);
        chk({tag, "_start"}, 16'(bus.filt_start), 16'h0);
        chk({tag, "_adapt"}, 16'(bus.filt_adapt), 16'h0);
        chk({tag, "_busy"}, 16'(bus.busy), 16'h0);
        chk({tag, "_ovr"}, 16'(bus.overrun_cnt), 16'h0);
        chk({tag, "_to"}, 16'(bus.timeout_flag), 16'h0);
    endtask

    // mode 0: d then x, 1: both together (x must equal d), 2: d0 overwritten by d then x, 3: x then d.
    // k: filt_done asserted k cycles after launch; k > TIMEOUT means the engine never answers.
    task automatic run_pass(input int mode, input logic [15:0] d, input logic [15:0] x, input logic [15:0] d0,
                            input logic byp, input logic adp, input int k, input logic [15:0] err, input int drops);
        int end_j;
        int nd;
        bus.bypass   = byp;
        bus.adapt_en = adp;
        if (mode == 1) capture(2'b11, d);
        else if (mode == 3) begin
            capture(2'b01, x);
            gap();
            capture(2'b10, d);
        end else begin
            if (mode == 2) begin
                capture(2'b10, d0);
                chk("ovw_first", bus.filt_d, d0);
            end
            capture(2'b10, d);
            if (mode == 2) begin
                chk("ovw_second", bus.filt_d, d);
                chk("ovw_no_ovr", 16'(bus.overrun_cnt), 16'(exp_ovr));
                chk("ovw_not_busy", 16'(bus.busy), 16'h0);
            end
            gap();
            capture(2'b01, x);
        end
        chk("lat_d", bus.filt_d, d);
        chk("lat_x", bus.filt_x, x);
        bus.bypass   = ~byp;
        bus.adapt_en = ~adp;
        if (byp) begin
            chk("byp_no_start", 16'(bus.filt_start), 16'h0);
            chk("byp_not_busy", 16'(bus.busy), 16'h0);
            tick();
            exp_out = d;
            chk("byp_out", bus.audio_output, exp_out);
        end else begin
            chk("start", 16'(bus.filt_start), 16'h1);
            chk("adapt", 16'(bus.filt_adapt), 16'(adp));
            chk("busy_start", 16'(bus.busy), 16'h1);
            end_j = k <= TIMEOUT ? k : TIMEOUT;
            nd = 0;
            for (int j = 1; j <= end_j; j++) begin
                tick();
                bus.sample_end = 2'b00;
                if (j == 1) chk("start_once", 16'(bus.filt_start), 16'h0);
                if (j == k) begin
                    bus.filt_done = 1'b1;
                    bus.filt_err  = err;
                end
                if (nd < drops && j % 2 == 0 && j < end_j) begin
                    bus.sample_end  = nd == 3 ? 2'b01 : 2'b10;
                    bus.audio_input = 16'($urandom);
                    nd++;
                    drop();
                end
            end
            chk("busy_hold", 16'(bus.busy), 16'h1);
            chk("out_hold", bus.audio_output, exp_out);
            tick();
            bus.filt_done = 1'b0;
            bus.filt_err  = 16'($urandom);
            exp_out = k <= TIMEOUT ? err : d;
            if (k > TIMEOUT) exp_to = 1'b1;
            chk("out", bus.audio_output, exp_out);
            chk("busy_end", 16'(bus.busy), 16'h0);
            chk("keep_d", bus.filt_d, d);
            chk("keep_x", bus.filt_x, x);
        end
        chk("timeout_flag", 16'(bus.timeout_flag), 16'(exp_to));
        chk("overrun", 16'(bus.overrun_cnt), 16'(exp_ovr));
        tick();
        chk("idle_out", bus.audio_output, exp_out);
    endtask

    task automatic rand_pass();
        int mode;
        logic [15:0] d;
        mode = $urandom_range(0, 3);
        d = 16'($urandom);
        run_pass(mode, d, mode == 1 ? d : 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), $urandom_range(1, TIMEOUT - 1), 16'($urandom), 0);
    endtask

    initial begin
        bus.sample_end = 2'b00;
        bus.sample_req = 2'b00;
        bus.audio_input = '0;
        bus.bypass = 1'b0;
        bus.adapt_en = 1'b0;
        bus.filt_done = 1'b0;
        bus.filt_err = '0;
        repeat (2) tick();
        chk_zero("reset");
        #2 reset_n = 1'b1;
        tick();
        bus.sample_req = 2'b11;
        run_pass(0, 16'h1234, 16'h0F00, 16'h0, 1'b0, 1'b1, 5, 16'hFFF0, 0);
        run_pass(0, 16'h7FFF, 16'h0001, 16'h0, 1'b1, 1'b0, 0, 16'h0, 0);
        run_pass(0, 16'($urandom), 16'($urandom), 16'h0, 1'b0, 1'b0, 10, 16'($urandom), 4);
        run_pass(2, 16'h0200, 16'($urandom), 16'h0100, 1'b0, 1'b1, 3, 16'($urandom), 0);
        run_pass(1, 16'h0055, 16'h0055, 16'h0, 1'b0, 1'b1, 1, 16'($urandom), 0);
        repeat (8) rand_pass();
        // hold both strobes: each BYPASS/COMMIT cycle is a dropped capture
        bus.bypass = 1'b1;
        bus.sample_end = 2'b11;
        bus.audio_input = 16'hA5C3;
        repeat (30) tick();
        repeat (20) drop();
        chk("sat_partial", 16'(bus.overrun_cnt), 16'(exp_ovr));
        repeat (420) tick();
        repeat (280) drop();
        bus.sample_end = 2'b00;
        exp_out = 16'hA5C3;
        chk("sat_full", 16'(bus.overrun_cnt), 16'(exp_ovr));
        chk("sat_out", bus.audio_output, exp_out);
        run_pass(0, 16'($urandom), 16'($urandom), 16'h0, 1'b0, 1'b1, 40, 16'($urandom), 0);
        repeat (3) rand_pass();
        run_pass(3, 16'($urandom), 16'($urandom), 16'h0, 1'b0, 1'b0, TIMEOUT, 16'($urandom), 0);
        bus.bypass = 1'b0;
        capture(2'b10, 16'($urandom));
        capture(2'b01, 16'($urandom));
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        #1 reset_n = 1'b1;
        exp_out = '0;
        exp_to = 1'b0;
        exp_ovr = 0;
        tick();
        bus.filt_done = 1'b1;
        bus.filt_err = 16'hBEEF;
        tick();
        bus.filt_done = 1'b0;
        chk("stray_done_out", bus.audio_output, exp_out);
        chk("stray_done_busy", 16'(bus.busy), 16'h0);
        run_pass(0, 16'h4321, 16'h0BAD, 16'h0, 1'b0, 1'b1, 7, 16'h1357, 0);
        rand_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
